// File: rtl/m_wb_regbank_if.sv
// Wishbone classic bus bundle for m_wb_regbank.
// Signal names follow the Wishbone slave-side naming of the bank.
interface m_wb_regbank_if #(
  parameter int unsigned ADRW = 2
);
  logic            STB_I;
  logic            WE_I;
  logic [3:0]      SEL_I;
  logic [ADRW-1:0] ADR_I;
  logic [31:0]     DAT_I;
  logic [31:0]     DAT_O;
  logic            ACK_O;

  modport master (
    output STB_I, WE_I, SEL_I, ADR_I, DAT_I,
    input  DAT_O, ACK_O
  );

  modport slave (
    input  STB_I, WE_I, SEL_I, ADR_I, DAT_I,
    output DAT_O, ACK_O
  );
endinterface

// File: rtl/m_wb_regbank.sv
// Bank of NREG byte-writable 32-bit registers behind a Wishbone classic slave port,
// with configurable ACK wait states, per-register write-commit pulses and a flat
// register output. Optional macro M_WB_REGBANK_STICKY_EN turns the last register
// into a write-1-to-clear sticky status register fed by sts_set.
module m_wb_regbank #(
  parameter int unsigned NREG       = 4,
  parameter int unsigned ADRW       = 2,
  parameter int unsigned WAITSTATES = 0,
  parameter logic [31:0] RESETVAL   = 32'h0
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  m_wb_regbank_if.slave        bus,
  output logic [NREG-1:0]      wrpulse,
  output logic [32*NREG-1:0]   regs_o
`ifdef M_WB_REGBANK_STICKY_EN
  ,
  input  logic [31:0]          sts_set
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  // Counter is loaded one short so that ACK lands WAITSTATES cycles after WAIT entry.
  localparam int unsigned WaitLoadInt = (WAITSTATES > 0) ? WAITSTATES - 1 : 0;
  localparam logic [2:0]  WaitLoad    = WaitLoadInt[2:0];

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [31:0]     regs_q [NREG];
  logic [31:0]     regs_d [NREG];
  logic [NREG-1:0] wrpulse_q, wrpulse_d;
  logic [ADRW-1:0] adr;
  logic [31:0]     byte_mask;
  logic            ack;
  logic            commit;

  assign adr    = bus.ADR_I;
  assign ack    = (state_q == StAck);
  assign commit = ack & bus.STB_I & bus.WE_I;

  // FSM state and wait counter register
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: IDLE -> (WAIT) -> ACK -> IDLE; dropped strobe aborts WAIT
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.STB_I) begin
          if (WAITSTATES == 0) begin
            state_d = StAck;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
        end
      end
      StWait: begin
        if (!bus.STB_I) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Expand byte enables to a bit mask
  always_comb begin
    byte_mask = '0;
    for (int k = 0; k < 4; k++) begin
      byte_mask[8*k +: 8] = {8{bus.SEL_I[k]}};
    end
  end

  // Register next state: byte-masked write at ACK, plus sticky set/clear if enabled
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    wrpulse_d = '0;
    if (commit) begin
      regs_d[adr]    = (regs_q[adr] & ~byte_mask) | (bus.DAT_I & byte_mask);
      wrpulse_d[adr] = 1'b1;
    end
`ifdef M_WB_REGBANK_STICKY_EN
    // Write-1-to-clear, with set taking priority over a same-cycle clear.
    if (commit && (adr == ADRW'(NREG - 1))) begin
      regs_d[NREG-1] = (regs_q[NREG-1] & ~(bus.DAT_I & byte_mask)) | sts_set;
    end else begin
      regs_d[NREG-1] = regs_q[NREG-1] | sts_set;
    end
`endif
  end

  // Register storage and write-commit pulse
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= RESETVAL;
      end
`ifdef M_WB_REGBANK_STICKY_EN
      regs_q[NREG-1] <= '0;
`endif
      wrpulse_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wrpulse_q <= wrpulse_d;
    end
  end

  // Read data is zero outside the ACK cycle so the bus can be OR-combined
  assign bus.DAT_O = ack ? regs_q[adr] : '0;
  assign bus.ACK_O = ack;
  assign wrpulse   = wrpulse_q;

  for (genvar i = 0; i < NREG; i++) begin : g_flat
    assign regs_o[32*i +: 32] = regs_q[i];
  end

endmodule
